ofdm_rx_cp_deframer: RTL
========================

# ofdm_rx_cp_deframer

Receive-side counterpart of the transmit chain's cyclic-prefix insertion and parallel-to-serial stages. The block accepts a serial stream of complex baseband samples, one per valid cycle, framed as `cycle_prefix + FFT_size` samples per OFDM symbol. It discards the prefix and collects the remaining `FFT_size` samples into a parallel real/imag vector for the downstream FFT. A one-deep output register with valid/ready handshake decouples collection from FFT consumption.

## Interface
- `Data_Width`, 32, width of each signed sample component
- `FFT_size`, 8, data samples per symbol (≥2)
- `cycle_prefix`, 2, prefix samples per symbol (≥1)
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-low reset
- `in_valid` in 1: input sample present this cycle
- `in_sof` in 1: qualifies the first prefix sample of a symbol (ignored unless `in_valid`)
- `in_real` in signed `Data_Width`: sample real part
- `in_imag` in signed `Data_Width`: sample imaginary part
- `out_real` out signed `Data_Width` × `FFT_size` (unpacked): collected real vector, index 0 = first post-prefix sample
- `out_imag` out signed `Data_Width` × `FFT_size`: collected imaginary vector
- `out_valid` out 1: output vector holds an unconsumed symbol
- `out_ready` in 1: downstream accepts the vector when `out_valid`
- `overflow` out 1: sticky; a completed symbol was dropped
- `sync_err` out 1: sticky; `in_sof` arrived mid-symbol
- `sym_count` out 16: count of symbols delivered to output register, wraps at 2^16

## Operation
- FSM states: IDLE, CP, DATA. Counter `idx` tracks position within the current phase.
- Every transition is gated by `in_valid`. When `in_valid`=0, nothing changes (stall).
- IDLE: on `in_valid & in_sof`, the sample is discarded as prefix sample 0. Next state is CP with `idx`=1, or DATA with `idx`=0 when `cycle_prefix`=1. Valid samples without `in_sof` are ignored.
- CP: each valid sample is discarded and increments `idx`. The sample with `idx`=`cycle_prefix`-1 moves the FSM to DATA with `idx`=0.
- DATA: each valid sample is written to collect buffer slot `idx`. On slot `FFT_size`-1 the symbol completes and the FSM returns to IDLE.
- IDLE accepts `in_sof` on the very next cycle, so back-to-back symbols run with no gap.
- Symbol completion transfer:
  - If the output register is empty, or is drained this same cycle (`out_valid & out_ready`), the collect buffer plus the final sample are copied into `out_real`/`out_imag`. `out_valid` is set and `sym_count` increments.
  - Otherwise the symbol is dropped, `overflow` is set, and the output register is unchanged.
- `in_sof` seen in CP or DATA: set `sync_err`, discard the partial symbol, and treat the sample as prefix sample 0 (same action as IDLE).
- Handshake: `out_valid` stays high and the vectors stay stable until `out_valid & out_ready`. On that cycle `out_valid` clears, unless a new symbol loads in the same cycle, in which case it stays high with the new data.
- Sticky flags clear only on reset.
- No arithmetic is applied to samples; they are stored bit-exact.

## Timing
- Reset (async assert) forces: state IDLE, `idx`=0, `out_valid`=0, `out_real`/`out_imag` all 0, `overflow`=0, `sync_err`=0, `sym_count`=0. Reset released mid-symbol restarts cleanly in IDLE.
- Latency: `out_valid` rises on the clock edge that samples the last data sample, so it is visible one cycle after that sample is presented.
- Minimum symbol period is `cycle_prefix + FFT_size` cycles. Sustained throughput needs `out_ready` asserted within `cycle_prefix + FFT_size` cycles of `out_valid`.
- `out_ready` has no combinational path to any output.

## Structure
- Package `ofdm_pkg` holds the default `Data_Width`/`FFT_size`/`cycle_prefix` constants and the FSM state enum `cp_state_t` (IDLE, CP, DATA).
- One sub-module, `rx_symbol_buffer`, contains the collect buffer and the output register with transfer/handshake logic. The FSM and counters stay in the top.

## Test plan
- Single symbol: sof on sample 100, samples 100..109 (imag = negated real), `out_ready`=1 → `out_real`=102..109, `out_imag`=-102..-109, `out_valid` high one cycle after sample 109, `sym_count`=1.
- Back-to-back: three symbols with no gaps, `out_ready`=1 → three vectors, `sym_count`=3, flags 0.
- Stalls: `in_valid` toggled randomly through one symbol → same vector as the no-stall case.
- Backpressure: `out_ready`=0 across two full symbols → first vector held, `overflow`=1, second dropped. Raise `out_ready` → vector 1 accepted, `out_valid` drops.
- Resync: sof, then 5 samples, then sof again followed by a full symbol 200..209 → `sync_err`=1, output = 202..209.
- Async reset asserted mid-DATA → all outputs 0 immediately. After release, a fresh symbol decodes correctly.

Source files
------------

// File: rtl/ofdm_rx_cp_deframer_pkg.sv
// Shared constants and FSM state type for the OFDM receive cyclic-prefix deframer.
package ofdm_pkg;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int FFT_SIZE_DEF     = 8;
  localparam int CYCLE_PREFIX_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    DATA = 2'd2
  } cp_state_t;
endpackage

// File: rtl/ofdm_rx_cp_deframer_if.sv
// Sample-stream input and parallel-vector output bundle of the CP deframer.
interface ofdm_rx_cp_deframer_if
  import ofdm_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int FFT_size   = FFT_SIZE_DEF
);
  logic                         in_valid;
  logic                         in_sof;
  logic signed [Data_Width-1:0] in_real;
  logic signed [Data_Width-1:0] in_imag;
  logic signed [Data_Width-1:0] out_real [FFT_size];
  logic signed [Data_Width-1:0] out_imag [FFT_size];
  logic                         out_valid;
  logic                         out_ready;
  logic                         overflow;
  logic                         sync_err;
  logic [15:0]                  sym_count;

  modport slave (
    input  in_valid, in_sof, in_real, in_imag, out_ready,
    output out_real, out_imag, out_valid, overflow, sync_err, sym_count
  );

  modport master (
    output in_valid, in_sof, in_real, in_imag, out_ready,
    input  out_real, out_imag, out_valid, overflow, sync_err, sym_count
  );
endinterface

// File: rtl/ofdm_rx_cp_deframer_buf.sv
// Collect buffer plus one-deep output vector register with valid/ready handshake.
module rx_symbol_buffer
  import ofdm_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int FFT_size   = FFT_SIZE_DEF,
  parameter int IDX_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic signed [Data_Width-1:0] wr_real,
  input  logic signed [Data_Width-1:0] wr_imag,
  input  logic                         sym_done,
  input  logic                         out_ready,
  output logic signed [Data_Width-1:0] out_real [FFT_size],
  output logic signed [Data_Width-1:0] out_imag [FFT_size],
  output logic                         out_valid,
  output logic                         overflow,
  output logic [15:0]                  sym_count
);
  logic signed [Data_Width-1:0] col_real [FFT_size];
  logic signed [Data_Width-1:0] col_imag [FFT_size];
  logic load;
  logic drain;

  assign drain = out_valid & out_ready;
  assign load  = sym_done & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      col_real[wr_idx] <= wr_real;
      col_imag[wr_idx] <= wr_imag;
    end
  end

  // The final sample bypasses the collect buffer so the vector lands on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      sym_count <= 16'd0;
      for (int i = 0; i < FFT_size; i++) begin
        out_real[i] <= '0;
        out_imag[i] <= '0;
      end
    end else begin
      if (load) begin
        for (int i = 0; i < FFT_size - 1; i++) begin
          out_real[i] <= col_real[i];
          out_imag[i] <= col_imag[i];
        end
        out_real[FFT_size-1] <= wr_real;
        out_imag[FFT_size-1] <= wr_imag;
        out_valid <= 1'b1;
        sym_count <= sym_count + 16'd1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (sym_done && !load) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/ofdm_rx_cp_deframer.sv
// Strips the cyclic prefix from a framed serial sample stream and hands each symbol out as a vector.
module ofdm_rx_cp_deframer
  import ofdm_pkg::*;
#(
  parameter int Data_Width   = DATA_WIDTH_DEF,
  parameter int FFT_size     = FFT_SIZE_DEF,
  parameter int cycle_prefix = CYCLE_PREFIX_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  ofdm_rx_cp_deframer_if.slave    bus
);
  localparam int IDX_W = (FFT_size > cycle_prefix) ? $clog2(FFT_size) : $clog2(cycle_prefix);
  localparam logic [IDX_W-1:0] CP_LAST  = IDX_W'(cycle_prefix - 1);
  localparam logic [IDX_W-1:0] FFT_LAST = IDX_W'(FFT_size - 1);

  cp_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             wr_en;
  logic             sym_done;
  logic             sync_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      bus.sync_err <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (sync_set) bus.sync_err <= 1'b1;
    end
  end

  // A valid sof restarts framing from any state; mid-symbol it also flags a sync error.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    sym_done  = 1'b0;
    sync_set  = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        sync_set = (state != IDLE);
        if (cycle_prefix == 1) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end else begin
          state_nxt = CP;
          idx_nxt   = IDX_W'(1);
        end
      end else begin
        case (state)
          CP: begin
            if (idx == CP_LAST) begin
              state_nxt = DATA;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
          DATA: begin
            wr_en = 1'b1;
            if (idx == FFT_LAST) begin
              sym_done  = 1'b1;
              state_nxt = IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  rx_symbol_buffer #(
    .Data_Width (Data_Width),
    .FFT_size   (FFT_size),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (idx),
    .wr_real   (bus.in_real),
    .wr_imag   (bus.in_imag),
    .sym_done  (sym_done),
    .out_ready (bus.out_ready),
    .out_real  (bus.out_real),
    .out_imag  (bus.out_imag),
    .out_valid (bus.out_valid),
    .overflow  (bus.overflow),
    .sym_count (bus.sym_count)
  );
endmodule
